cpu_sdram_bridge: RTL and testbench

CPU_SDRAM_BRIDGE -- requirements
Module: cpu_sdram_bridge

---
 rtl/cpu_sdram_bridge.sv | 185 ++++++++++++++++++
 tb/tb_cpu_sdram_bridge.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sdram_bridge.sv
// Bridges a valid/ready CPU request onto the SDRAM controller CPU port, splitting
// longwords into a high-word phase, one idle gap cycle and a low-word phase.
module cpu_sdram_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_114,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  input  logic        req_we,
  input  logic        req_fetch,
  input  logic        req_long,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [23:0] cpuAddr,
  output logic [6:0]  cpustate,
  output logic        cpuL,
  output logic        cpuU,
  output logic [15:0] cpuWR,
  input  logic [15:0] cpuRD,
  input  logic        cpuena
);

  typedef enum logic [2:0] {IDLE, HI, GAP, LO, RESP} state_t;

  localparam logic [7:0] TIMEOUT_W     = 8'(TIMEOUT);
  localparam logic [6:0] CPUSTATE_IDLE = 7'b0000101;

  state_t      state_q, state_d;
  logic [23:0] addr_q, addr_d;
  logic        we_q, we_d, fetch_q, fetch_d, long_q, long_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] hi_q, hi_d, lo_q, lo_d;
  logic [7:0]  wd_q, wd_d;
  logic        timed_out;
  logic [1:0]  mode;

  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [23:0] cpu_addr_q, cpu_addr_d;
  logic [6:0]  cpustate_q, cpustate_d;
  logic        cpu_l_q, cpu_l_d, cpu_u_q, cpu_u_d;
  logic [15:0] cpu_wr_q, cpu_wr_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    fetch_d   = fetch_q;
    long_d    = long_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    wd_d      = 8'd0;
    timed_out = 1'b0;

    unique case (state_q)
      IDLE: if (req_valid) begin
        addr_d  = req_addr;
        we_d    = req_we;
        fetch_d = req_fetch;
        long_d  = req_long;
        be_d    = req_be;
        wdata_d = req_wdata;
        hi_d    = 16'h0;
        lo_d    = 16'h0;
        state_d = HI;
      end
      HI, LO: begin
        if (cpuena) begin
          if (state_q == HI && long_q) begin
            hi_d    = cpuRD;
            state_d = GAP;
          end else begin
            lo_d    = cpuRD;
            state_d = RESP;
          end
        end else if (wd_q + 8'd1 == TIMEOUT_W) begin
          // The watchdog's next value would hit the limit: abandon remaining phases.
          timed_out = 1'b1;
          state_d   = RESP;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      GAP:     state_d = LO;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are computed from the next state so they are registered yet phase-aligned.
    mode        = we_d ? 2'b11 : (fetch_d ? 2'b00 : 2'b10);
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    rsp_err_d   = timed_out;
    rsp_rdata_d = 32'h0;
    if (state_d == RESP && !timed_out && !we_d)
      rsp_rdata_d = long_d ? {hi_d, lo_d} : {16'h0, lo_d};

    cpustate_d = CPUSTATE_IDLE;
    cpu_l_d    = 1'b1;
    cpu_u_d    = 1'b1;
    cpu_addr_d = cpu_addr_q;
    cpu_wr_d   = cpu_wr_q;
    if (state_d == HI || state_d == LO) begin
      cpustate_d = {long_d, 4'b0000, mode};
      if (state_d == HI && long_d) begin
        cpu_addr_d = addr_d;
        cpu_l_d    = ~be_d[2];
        cpu_u_d    = ~be_d[3];
        cpu_wr_d   = wdata_d[31:16];
      end else begin
        cpu_addr_d = (state_d == LO) ? addr_d + 24'd1 : addr_d;
        cpu_l_d    = ~be_d[0];
        cpu_u_d    = ~be_d[1];
        cpu_wr_d   = wdata_d[15:0];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_114) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= 24'h0;
      we_q        <= 1'b0;
      fetch_q     <= 1'b0;
      long_q      <= 1'b0;
      be_q        <= 4'h0;
      wdata_q     <= 32'h0;
      hi_q        <= 16'h0;
      lo_q        <= 16'h0;
      wd_q        <= 8'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
      cpu_addr_q  <= 24'h0;
      cpustate_q  <= CPUSTATE_IDLE;
      cpu_l_q     <= 1'b1;
      cpu_u_q     <= 1'b1;
      cpu_wr_q    <= 16'h0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      fetch_q     <= fetch_d;
      long_q      <= long_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      wd_q        <= wd_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      cpu_addr_q  <= cpu_addr_d;
      cpustate_q  <= cpustate_d;
      cpu_l_q     <= cpu_l_d;
      cpu_u_q     <= cpu_u_d;
      cpu_wr_q    <= cpu_wr_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign cpuAddr   = cpu_addr_q;
  assign cpustate  = cpustate_q;
  assign cpuL      = cpu_l_q;
  assign cpuU      = cpu_u_q;
  assign cpuWR     = cpu_wr_q;

endmodule

// File: tb/tb_cpu_sdram_bridge.sv
// Directed and randomized transactions checked against a phase-level model of the
// bridge protocol: expected port values are derived per phase from the request.
module tb_cpu_sdram_bridge;

  localparam int unsigned TO = 255;

  logic        clk_114 = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [23:0] req_addr;
  logic        req_we, req_fetch, req_long;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [23:0] cpuAddr;
  logic [6:0]  cpustate;
  logic        cpuL, cpuU;
  logic [15:0] cpuWR, cpuRD;
  logic        cpuena;

  always #5 clk_114 = ~clk_114;

  cpu_sdram_bridge #(.TIMEOUT(TO)) dut (
    .clk_114(clk_114), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_fetch(req_fetch), .req_long(req_long),
    .req_be(req_be), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .cpuAddr(cpuAddr), .cpustate(cpustate), .cpuL(cpuL), .cpuU(cpuU),
    .cpuWR(cpuWR), .cpuRD(cpuRD), .cpuena(cpuena)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Request currently owned by the model.
  logic [23:0] t_addr;
  logic        t_we, t_fetch, t_long;
  logic [3:0]  t_be;
  logic [31:0] t_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_114);
    #1;
  endtask

  task automatic scramble_req();
    req_addr  = 24'($urandom);
    req_we    = 1'($urandom);
    req_fetch = 1'($urandom);
    req_long  = 1'($urandom);
    req_be    = 4'($urandom);
    req_wdata = $urandom;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"},    32'(req_ready), 32'd1);
    chk({tag, "_rvalid"},   32'(rsp_valid), 32'd0);
    chk({tag, "_rerr"},     32'(rsp_err),   32'd0);
    chk({tag, "_rdata"},    rsp_rdata,      32'd0);
    chk({tag, "_addr"},     32'(cpuAddr),   32'd0);
    chk({tag, "_cpustate"}, 32'(cpustate),  32'h05);
    chk({tag, "_lu"},       32'({cpuL, cpuU}), 32'd3);
    chk({tag, "_wr"},       32'(cpuWR),     32'd0);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_cpustate"}, 32'(cpustate), 32'h05);
    chk({tag, "_lu"},       32'({cpuL, cpuU}), 32'd3);
  endtask

  // Expected port image for a HI or LO phase of the stored request.
  task automatic check_phase(input string tag, input bit lo);
    logic [1:0]  mode;
    logic [23:0] exp_addr;
    logic [1:0]  exp_lu;
    logic [15:0] exp_wr;
    mode     = t_we ? 2'b11 : (t_fetch ? 2'b00 : 2'b10);
    exp_addr = lo ? t_addr + 24'd1 : t_addr;
    if (!lo && t_long) begin
      exp_lu = {~t_be[2], ~t_be[3]};
      exp_wr = t_wdata[31:16];
    end else begin
      exp_lu = {~t_be[0], ~t_be[1]};
      exp_wr = t_wdata[15:0];
    end
    chk({tag, "_cpustate"}, 32'(cpustate), 32'({t_long, 4'b0000, mode}));
    chk({tag, "_addr"},     32'(cpuAddr),  32'(exp_addr));
    chk({tag, "_lu"},       32'({cpuL, cpuU}), 32'(exp_lu));
    chk({tag, "_wr"},       32'(cpuWR),    32'(exp_wr));
    chk({tag, "_rvalid"},   32'(rsp_valid), 32'd0);
    chk({tag, "_ready"},    32'(req_ready), 32'd0);
  endtask

  // Holds cpuena low for wait_c cycles then pulses it; wait_c >= TO means never.
  task automatic run_phase(input string tag, input bit lo, input int wait_c,
                           input logic [15:0] rd, output bit timed_out);
    timed_out = 1'b0;
    for (int c = 0; c < int'(TO); c++) begin
      if (c == 0) check_phase(tag, lo);
      if (c == wait_c) begin
        cpuena = 1'b1;
        cpuRD  = rd;
        step();
        cpuena = 1'b0;
        cpuRD  = 16'($urandom);
        return;
      end
      cpuRD = 16'($urandom);
      step();
    end
    timed_out = 1'b1;
  endtask

  task automatic txn(input logic [23:0] a, input logic we, input logic fe, input logic lg,
                     input logic [3:0] be, input logic [31:0] wd, input int hw, input int lw,
                     input logic [15:0] rh, input logic [15:0] rl);
    bit          to;
    bit          err;
    logic [31:0] exp_data;
    chk("idle_ready", 32'(req_ready), 32'd1);
    req_addr = a; req_we = we; req_fetch = fe; req_long = lg; req_be = be; req_wdata = wd;
    req_valid = 1'b1;
    t_addr = a; t_we = we; t_fetch = fe; t_long = lg; t_be = be; t_wdata = wd;
    step();
    req_valid = 1'b0;
    scramble_req();
    run_phase("hi", 1'b0, hw, rh, to);
    err = to;
    if (!to && lg) begin
      check_quiet("gap");
      chk("gap_rvalid", 32'(rsp_valid), 32'd0);
      cpuena = 1'($urandom);
      step();
      cpuena = 1'b0;
      run_phase("lo", 1'b1, lw, rl, to);
      err = to;
    end
    if (err || we)   exp_data = 32'h0;
    else if (lg)     exp_data = {rh, rl};
    else             exp_data = {16'h0, rh};
    chk("resp_valid", 32'(rsp_valid), 32'd1);
    chk("resp_err",   32'(rsp_err),   32'(err));
    chk("resp_rdata", rsp_rdata,      exp_data);
    chk("resp_ready", 32'(req_ready), 32'd0);
    check_quiet("resp");
    cpuena = 1'($urandom);
    step();
    cpuena = 1'b0;
    chk("after_valid", 32'(rsp_valid), 32'd0);
    chk("after_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    bit to;
    reset = 1'b1; req_valid = 1'b0; cpuena = 1'b0; cpuRD = 16'h0;
    scramble_req();
    step(); step();
    check_reset_vals("reset");
    reset = 1'b0;
    step();
    check_reset_vals("post_reset");

    // Word read with three waits, then longword write across 0x0FF/0x100.
    txn(24'h000100, 1'b0, 1'b0, 1'b0, 4'b0011, 32'h0, 3, 0, 16'hBEEF, 16'h0);
    txn(24'h0000FF, 1'b1, 1'b0, 1'b1, 4'hF, 32'h12345678, 0, 0, 16'h1111, 16'h2222);
    // Longword read wrapping the address space.
    txn(24'hFFFFFF, 1'b0, 1'b0, 1'b1, 4'hF, 32'h0, 1, 2, 16'hAAAA, 16'h5555);
    // Single byte lanes on word writes.
    txn(24'h001234, 1'b1, 1'b0, 1'b0, 4'b0001, 32'hCAFE00AB, 0, 0, 16'h0, 16'h0);
    txn(24'h001235, 1'b1, 1'b0, 1'b0, 4'b0010, 32'hCAFEAB00, 2, 0, 16'h0, 16'h0);
    // Watchdog: no cpuena at all, cpuena on the last allowed cycle, LO-phase expiry.
    txn(24'h00ABCD, 1'b0, 1'b0, 1'b0, 4'b0011, 32'h0, int'(TO), 0, 16'h7777, 16'h0);
    txn(24'h00ABCE, 1'b0, 1'b1, 1'b0, 4'b0011, 32'h0, int'(TO) - 1, 0, 16'h1357, 16'h0);
    txn(24'h00ABCF, 1'b0, 1'b0, 1'b1, 4'hF, 32'h0, 1, int'(TO), 16'h2468, 16'h9999);

    // Reset while in LO of a longword read.
    t_addr = 24'h003000; t_we = 1'b0; t_fetch = 1'b0; t_long = 1'b1; t_be = 4'hF; t_wdata = 32'h0;
    req_addr = t_addr; req_we = 1'b0; req_fetch = 1'b0; req_long = 1'b1; req_be = 4'hF; req_wdata = 32'h0;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    run_phase("rst_hi", 1'b0, 0, 16'h4444, to);
    step();
    check_phase("rst_lo", 1'b1);
    reset = 1'b1;
    step();
    check_reset_vals("midop_reset");
    reset = 1'b0;
    step();
    check_reset_vals("midop_release");
    txn(24'h000040, 1'b0, 1'b1, 1'b0, 4'b0011, 32'h0, 0, 0, 16'h4E71, 16'h0);

    for (int n = 0; n < 60; n++) begin
      txn(24'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), $urandom,
          int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 16'($urandom), 16'($urandom));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        cpuena = 1'($urandom);
        step();
        cpuena = 1'b0;
        check_quiet("idle_gap");
        chk("idle_gap_ready", 32'(req_ready), 32'd1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
